handshake_monitor_mc: RTL and testbench
=======================================

Name: handshake_monitor_mc

Overview:
- Parametrised, multi-channel ready/valid protocol monitor, bound alongside an RTL module to observe its handshake ports. Read-only observer; never drives the design under observation.
- Per channel: counts transfers, checks valid/data stability while stalled, detects stall timeouts.
- Reports sticky error flags plus the first-failing channel for bench and debug-register readout.

Parameters:
- NUM_CH, 4, number of monitored ready/valid channels (>=1).
- DATA_W, 5, payload width per channel.
- CNT_W, 16, transfer-counter width per channel.
- TIMEOUT, 16, consecutive stall cycles that raise a timeout (>=2).
- IDX_W, $clog2(NUM_CH) min 1, width of the channel-index output.

Ports:
- CLK  in  1  clock, rising edge.
- RESETN  in  1  synchronous active-low reset.
- valid  in  NUM_CH  per-channel valid.
- ready  in  NUM_CH  per-channel ready.
- data  in  NUM_CH*DATA_W  payloads, channel i at [i*DATA_W +: DATA_W].
- clear  in  1  synchronous clear of counters and error state.
- xfer_cnt  out  NUM_CH*CNT_W  per-channel transfer count, channel i at [i*CNT_W +: CNT_W].
- stalled  out  NUM_CH  channel currently in WAIT or TMO.
- err_drop  out  NUM_CH  sticky: valid deasserted before ready.
- err_data  out  NUM_CH  sticky: payload changed while stalled.
- err_tmo  out  NUM_CH  sticky: stall reached TIMEOUT.
- err_any  out  1  OR of all error bits (registered).
- first_err_vld  out  1  first-error capture valid.
- first_err_ch  out  IDX_W  channel of first error.

Behaviour:
- Reset: RESETN sampled low at a CLK edge sets every output to 0, every FSM to IDLE, and every stall counter to 0. Reset mid-stall discards the latched payload.
- All outputs are registered. Each event appears on outputs 1 cycle after the sampling edge.
- Transfer: valid[i]&ready[i] at an edge increments xfer_cnt[i]. Counter saturates at 2^CNT_W-1 and does not wrap.
- Per-channel FSM with states IDLE, WAIT, TMO:
  - IDLE: valid&!ready -> WAIT; latch payload; stall_cnt=1. valid&ready -> stay IDLE (transfer). !valid -> stay IDLE.
  - WAIT: valid&ready -> IDLE (transfer). !valid -> set err_drop -> IDLE. valid&!ready -> stall_cnt+1. When stall_cnt+1 == TIMEOUT: set err_tmo -> TMO.
  - TMO: same exits as WAIT; no further err_tmo action; stall_cnt holds.
  - In WAIT/TMO, any sampled data != latched payload sets err_data, including on the completing transfer cycle. The latched value is not updated.
- stalled[i] = 1 whenever FSM i is in WAIT or TMO.
- clear: highest priority after reset. Zeroes xfer_cnt, the err_* vectors, err_any, first_err_vld and first_err_ch. FSM state and stall counters are unaffected. Errors or transfers on the clear cycle are discarded.
- first_err_*: captured on the first edge at which any error bit rises while first_err_vld=0. If several channels fail on the same edge, the lowest index wins. Held until clear or reset.
- Simultaneous drop and data-change on the same edge: only err_drop is set, since data is irrelevant when valid is low.
- Channels are fully independent; no cross-channel ordering checks.

Optional Feature:
- Macro: HANDSHAKE_MONITOR_MC_ASSERT_EN.
- Defined: per-channel concurrent assertions on posedge CLK, disabled while !RESETN:
  - (valid&!ready) |=> valid
  - (valid&!ready) |=> $stable(data)
  - stall length < TIMEOUT
  Each failure calls $error with the channel index and the cycle time. Flag logic is unchanged.
- Undefined: no assertions or simulation messages; flags only. RTL ports and timing are identical in both builds.

Test Plan:
- Reset/idle: RESETN=0 for 2 cycles, then 10 idle cycles -> all outputs 0, stalled=0.
- Streaming: ch0 valid=ready=1 for 20 cycles, then clear=1 for 1 cycle -> xfer_cnt[0]=20, no errors; after clear, xfer_cnt[0]=0.
- Stall and complete: ch1 valid=1, ready=0 for 5 cycles, data=5'h0A held, then ready=1 -> stalled[1]=1 for 5 cycles, xfer_cnt[1]=1, no errors.
- Drop and data change:
  - ch2 stalls, data 5'h03 -> 5'h04 on the 2nd cycle -> err_data[2]=1, first_err_ch=2.
  - Then ch3 drops valid while stalled -> err_drop[3]=1, first_err_ch remains 2.
- Timeout: TIMEOUT=16, ch0 valid=1, ready=0 for 16 cycles -> err_tmo[0]=1 one cycle after the 16th edge; stall continues with no retrigger; ready=1 -> xfer_cnt[0]+1.
- Saturation/priority:
  - CNT_W=4, 20 transfers -> xfer_cnt=15.
  - Simultaneous errors on ch1 and ch3 -> first_err_ch=1.
  - clear on the same cycle as an error -> that error is not recorded.

Source files
------------

// File: rtl/handshake_monitor_mc.sv
// Multi-channel ready/valid observer: transfer counts, stall stability checks, stall timeouts.
// Define HANDSHAKE_MONITOR_MC_ASSERT_EN to add per-channel concurrent protocol assertions.
module handshake_monitor_mc #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 16,
  parameter int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic [NUM_CH-1:0]        valid,
  input  logic [NUM_CH-1:0]        ready,
  input  logic [NUM_CH*DATA_W-1:0] data,
  input  logic                     clear,
  output logic [NUM_CH*CNT_W-1:0]  xfer_cnt,
  output logic [NUM_CH-1:0]        stalled,
  output logic [NUM_CH-1:0]        err_drop,
  output logic [NUM_CH-1:0]        err_data,
  output logic [NUM_CH-1:0]        err_tmo,
  output logic                     err_any,
  output logic                     first_err_vld,
  output logic [IDX_W-1:0]         first_err_ch
);

  localparam int SC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TMO} state_t;

  logic [NUM_CH-1:0] drop_d_v, dchg_d_v, tmo_d_v, rise;
  logic              err_any_q, err_any_d;
  logic              fv_q, fv_d;
  logic [IDX_W-1:0]  fc_q, fc_d;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic              v, r;
    logic [DATA_W-1:0] dat;
    state_t            state_q, state_d;
    logic [SC_W-1:0]   stall_q, stall_d;
    logic [DATA_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d, dchg_q, dchg_d, tmo_q, tmo_d;

    assign v   = valid[gi];
    assign r   = ready[gi];
    assign dat = data[gi*DATA_W +: DATA_W];

    always_comb begin
      state_d = state_q;
      stall_d = stall_q;
      lat_d   = lat_q;
      cnt_d   = cnt_q;
      drop_d  = drop_q;
      dchg_d  = dchg_q;
      tmo_d   = tmo_q;
      if (v && r && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (v && !r) begin
            state_d = ST_WAIT;
            lat_d   = dat;
            stall_d = SC_W'(1);
          end
        end
        default: begin
          // a drop masks any payload difference on the same edge
          if (!v) begin
            drop_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            if (dat != lat_q) dchg_d = 1'b1;
            if (r) begin
              state_d = ST_IDLE;
            end else if (state_q == ST_WAIT) begin
              stall_d = stall_q + 1'b1;
              if (stall_d == SC_W'(TIMEOUT)) begin
                tmo_d   = 1'b1;
                state_d = ST_TMO;
              end
            end
          end
        end
      endcase
      if (clear) begin
        cnt_d  = '0;
        drop_d = 1'b0;
        dchg_d = 1'b0;
        tmo_d  = 1'b0;
      end
    end

    always_ff @(posedge CLK) begin
      if (!RESETN) begin
        state_q <= ST_IDLE;
        stall_q <= '0;
        lat_q   <= '0;
        cnt_q   <= '0;
        drop_q  <= 1'b0;
        dchg_q  <= 1'b0;
        tmo_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        stall_q <= stall_d;
        lat_q   <= lat_d;
        cnt_q   <= cnt_d;
        drop_q  <= drop_d;
        dchg_q  <= dchg_d;
        tmo_q   <= tmo_d;
      end
    end

    assign drop_d_v[gi] = drop_d;
    assign dchg_d_v[gi] = dchg_d;
    assign tmo_d_v[gi]  = tmo_d;
    assign xfer_cnt[gi*CNT_W +: CNT_W] = cnt_q;
    assign stalled[gi]  = (state_q != ST_IDLE);
    assign err_drop[gi] = drop_q;
    assign err_data[gi] = dchg_q;
    assign err_tmo[gi]  = tmo_q;

`ifdef HANDSHAKE_MONITOR_MC_ASSERT_EN
    a_valid_hold: assert property (@(posedge CLK) disable iff (!RESETN) (v && !r) |=> v)
      else $error("ch %0d: valid dropped while stalled at %0t", gi, $time);
    a_data_stable: assert property (@(posedge CLK) disable iff (!RESETN) (v && !r) |=> $stable(dat))
      else $error("ch %0d: data changed while stalled at %0t", gi, $time);
    a_stall_len: assert property (@(posedge CLK) disable iff (!RESETN)
                                  !(state_q == ST_WAIT && state_d == ST_TMO))
      else $error("ch %0d: stall reached timeout at %0t", gi, $time);
`endif
  end

  assign rise = (drop_d_v & ~err_drop) | (dchg_d_v & ~err_data) | (tmo_d_v & ~err_tmo);

  always_comb begin
    err_any_d = |(drop_d_v | dchg_d_v | tmo_d_v);
    fv_d      = fv_q;
    fc_d      = fc_q;
    if (!fv_q && (|rise)) begin
      fv_d = 1'b1;
      // descending scan so the lowest failing index is the last one written
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (rise[i]) fc_d = IDX_W'(i);
      end
    end
    if (clear) begin
      fv_d = 1'b0;
      fc_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      err_any_q <= 1'b0;
      fv_q      <= 1'b0;
      fc_q      <= '0;
    end else begin
      err_any_q <= err_any_d;
      fv_q      <= fv_d;
      fc_q      <= fc_d;
    end
  end

  assign err_any       = err_any_q;
  assign first_err_vld = fv_q;
  assign first_err_ch  = fc_q;

endmodule

// File: tb/tb_handshake_monitor_mc.sv
// Directed bench for handshake_monitor_mc; a second CNT_W=4 instance shares stimulus for saturation.
module tb_handshake_monitor_mc;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [3:0]  valid, ready;
  logic [19:0] data;
  logic        clear;

  logic [63:0] xfer_cnt;
  logic [3:0]  stalled, err_drop, err_data, err_tmo;
  logic        err_any, first_err_vld;
  logic [1:0]  first_err_ch;

  logic [15:0] s_xfer_cnt;
  logic [3:0]  s_stalled, s_err_drop, s_err_data, s_err_tmo;
  logic        s_err_any, s_first_err_vld;
  logic [1:0]  s_first_err_ch;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  handshake_monitor_mc dut (
    .CLK(CLK), .RESETN(RESETN), .valid(valid), .ready(ready), .data(data), .clear(clear),
    .xfer_cnt(xfer_cnt), .stalled(stalled), .err_drop(err_drop), .err_data(err_data),
    .err_tmo(err_tmo), .err_any(err_any), .first_err_vld(first_err_vld),
    .first_err_ch(first_err_ch)
  );

  handshake_monitor_mc #(.CNT_W(4)) dut_sat (
    .CLK(CLK), .RESETN(RESETN), .valid(valid), .ready(ready), .data(data), .clear(clear),
    .xfer_cnt(s_xfer_cnt), .stalled(s_stalled), .err_drop(s_err_drop), .err_data(s_err_data),
    .err_tmo(s_err_tmo), .err_any(s_err_any), .first_err_vld(s_first_err_vld),
    .first_err_ch(s_first_err_ch)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("chk %s got=%0h exp=%0h ok", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESETN = 1'b0; valid = '0; ready = '0; data = '0; clear = 1'b0;
    #1;
    tick(); tick();
    check("rst_cnt", xfer_cnt[31:0], 32'h0);
    check("rst_stalled", {28'h0, stalled}, 32'h0);
    check("rst_err", {20'h0, err_drop, err_data, err_tmo}, 32'h0);
    check("rst_any_fv", {30'h0, err_any, first_err_vld}, 32'h0);
    RESETN = 1'b1;
    repeat (10) tick();
    check("idle_cnt", xfer_cnt[63:32], 32'h0);
    check("idle_stalled", {28'h0, stalled}, 32'h0);
    check("idle_any", {31'h0, err_any}, 32'h0);

    // streaming on ch0, then clear
    valid[0] = 1'b1; ready[0] = 1'b1;
    repeat (20) tick();
    check("stream_cnt0", {16'h0, xfer_cnt[15:0]}, 32'd20);
    check("stream_sat", {28'h0, s_xfer_cnt[3:0]}, 32'd15);
    check("stream_noerr", {31'h0, err_any}, 32'h0);
    valid[0] = 1'b0; ready[0] = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_cnt0", {16'h0, xfer_cnt[15:0]}, 32'd0);

    // stall and complete on ch1
    data[9:5] = 5'h0A; valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall1_%0d", k), {31'h0, stalled[1]}, 32'h1);
    end
    ready[1] = 1'b1;
    tick();
    check("cmpl1_stalled", {31'h0, stalled[1]}, 32'h0);
    check("cmpl1_cnt", {16'h0, xfer_cnt[31:16]}, 32'd1);
    check("cmpl1_noerr", {31'h0, err_any}, 32'h0);
    valid[1] = 1'b0; ready[1] = 1'b0;

    // data change on ch2
    data[14:10] = 5'h03; valid[2] = 1'b1;
    tick();
    data[14:10] = 5'h04;
    tick();
    check("dchg_err", {28'h0, err_data}, 32'h4);
    check("dchg_fv", {31'h0, first_err_vld}, 32'h1);
    check("dchg_fch", {30'h0, first_err_ch}, 32'h2);
    check("dchg_any", {31'h0, err_any}, 32'h1);
    ready[2] = 1'b1;
    tick();
    valid[2] = 1'b0; ready[2] = 1'b0;
    // drop on ch3
    valid[3] = 1'b1;
    tick();
    valid[3] = 1'b0;
    tick();
    check("drop_err", {28'h0, err_drop}, 32'h8);
    check("drop_fch", {30'h0, first_err_ch}, 32'h2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_err", {26'h0, err_any, first_err_vld, err_data}, 32'h0);

    // timeout on ch0
    data[4:0] = 5'h11; valid[0] = 1'b1;
    repeat (15) tick();
    check("tmo_pre", {28'h0, err_tmo}, 32'h0);
    tick();
    check("tmo_set", {28'h0, err_tmo}, 32'h1);
    check("tmo_stalled", {31'h0, stalled[0]}, 32'h1);
    check("tmo_fch", {29'h0, first_err_vld, first_err_ch}, 32'h4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (3) tick();
    check("tmo_noretrig", {28'h0, err_tmo}, 32'h0);
    check("tmo_still", {31'h0, stalled[0]}, 32'h1);
    ready[0] = 1'b1;
    tick();
    check("tmo_xfer", {16'h0, xfer_cnt[15:0]}, 32'd1);
    check("tmo_done", {31'h0, stalled[0]}, 32'h0);
    valid[0] = 1'b0; ready[0] = 1'b0;

    // simultaneous drops on ch1 and ch3
    valid[1] = 1'b1; valid[3] = 1'b1;
    tick();
    valid[1] = 1'b0; valid[3] = 1'b0;
    tick();
    check("prio_drop", {28'h0, err_drop}, 32'hA);
    check("prio_fch", {29'h0, first_err_vld, first_err_ch}, 32'h5);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // error and transfer on the clear cycle are discarded
    valid[2] = 1'b1;
    tick();
    valid[2] = 1'b0; valid[0] = 1'b1; ready[0] = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0; valid[0] = 1'b0; ready[0] = 1'b0;
    check("clrerr_drop", {28'h0, err_drop}, 32'h0);
    check("clrerr_any_fv", {30'h0, err_any, first_err_vld}, 32'h0);
    check("clrerr_cnt0", {16'h0, xfer_cnt[15:0]}, 32'd0);
    tick();
    check("clrerr_after", {28'h0, err_drop}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
